// File: rtl/shared_ff_arbiter.sv
// Round-robin arbiter sharing one registered lane among N_REQ bursting requesters; beat appears on O one cycle after acceptance.
// Backpressure: req_ready is one-hot (or zero) to the current grantee only; non-granted requesters stall with valid held.
module shared_ff_arbiter #(
    parameter int N_REQ     = 2,
    parameter int WIDTH     = 1,
    parameter int BURST_MAX = 4,
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_last,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]         O,
    output logic                     O_valid,
    output logic [OW-1:0]            O_owner,
    output logic                     busy
);
    typedef enum logic { S_IDLE, S_OWNED } state_t;

    state_t            r_state;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     r_rr_ptr;
    logic [BW-1:0]     r_beat;
    logic [WIDTH-1:0]  r_o;
    logic              r_o_valid;
    logic [OW-1:0]     r_o_owner;

    logic              w_found;
    logic [OW-1:0]     w_win;
    logic [OW:0]       w_cand;
    logic [OW-1:0]     w_sel;
    logic              w_grant;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_data;

    function automatic logic [OW-1:0] f_next(input logic [OW-1:0] x);
        return (x == OW'(N_REQ - 1)) ? '0 : x + OW'(1);
    endfunction

    // Wrap-around scan starting at the round-robin pointer
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (OW+1)'(k);
            if (w_cand >= (OW+1)'(N_REQ))
                w_cand = w_cand - (OW+1)'(N_REQ);
            if (!w_found && req_valid[w_cand[OW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[OW-1:0];
            end
        end
    end

    always_comb begin
        w_sel   = (r_state == S_OWNED) ? r_owner : w_win;
        w_grant = !RESET && ((r_state == S_OWNED) || w_found);
        w_xfer  = w_grant && req_valid[w_sel];
        w_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == OW'(i))
                w_data = req_data[i*WIDTH +: WIDTH];
        end
    end

    assign req_ready = w_grant ? (N_REQ'(1) << w_sel) : '0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_beat    <= '0;
            r_o       <= '0;
            r_o_valid <= 1'b0;
            r_o_owner <= '0;
        end else begin
            if (w_xfer) begin
                r_o       <= w_data;
                r_o_valid <= 1'b1;
                r_o_owner <= w_sel;
            end else begin
                r_o_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        if (req_last[w_sel] || BURST_MAX == 1) begin
                            r_rr_ptr <= f_next(w_sel);
                        end else begin
                            r_state <= S_OWNED;
                            r_owner <= w_sel;
                            r_beat  <= BW'(1);
                        end
                    end
                end
                S_OWNED: begin
                    // No transfer here means the owner dropped valid: release without a beat
                    if (w_xfer && !req_last[r_owner] && r_beat != BW'(BURST_MAX - 1)) begin
                        r_beat <= r_beat + BW'(1);
                    end else begin
                        r_state  <= S_IDLE;
                        r_rr_ptr <= f_next(r_owner);
                        r_beat   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign O       = r_o;
    assign O_valid = r_o_valid;
    assign O_owner = r_o_owner;
    assign busy    = (r_state == S_OWNED);

endmodule

// File: tb/tb_shared_ff_arbiter.sv
// Bench for shared_ff_arbiter: directed scenarios plus random traffic against a grant/burst reference model,
// with accepted beats scoreboarded and matched by an independent output monitor.
module tb_shared_ff_arbiter;
    localparam int N  = 2;
    localparam int W  = 8;
    localparam int BM = 4;
    localparam int OW = 1;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_last;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     O;
    logic             O_valid;
    logic [OW-1:0]    O_owner;
    logic             busy;

    always #5 CLK = ~CLK;

    shared_ff_arbiter #(.N_REQ(N), .WIDTH(W), .BURST_MAX(BM)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .O(O), .O_valid(O_valid), .O_owner(O_owner), .busy(busy)
    );

    typedef struct packed {
        logic [OW-1:0] own;
        logic [W-1:0]  dat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: -1 means nobody holds the lane; beats counts beats taken in the current grant
    int m_owner = -1;
    int m_beats = 0;
    int m_rr    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic rst, input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic [N*W-1:0] d);
        int g;
        int nb;
        logic [N-1:0] er;
        logic x;
        exp_t e;
        @(negedge CLK);
        RESET     = rst;
        req_valid = v;
        req_last  = l;
        req_data  = d;
        #1;
        g = -1;
        if (!rst) begin
            if (m_owner >= 0) g = m_owner;
            else begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        er = '0;
        x  = 1'b0;
        if (g >= 0) begin
            er[g] = 1'b1;
            x = v[g];
        end
        chk("req_ready", int'(req_ready), int'(er));
        chk("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
        if (x) begin
            e.own = OW'(g);
            e.dat = d[g*W +: W];
            sb.push_back(e);
        end
        if (rst) begin
            m_owner = -1; m_beats = 0; m_rr = 0;
        end else if (g >= 0) begin
            if (x) begin
                nb = ((m_owner >= 0) ? m_beats : 0) + 1;
                if (l[g] || nb == BM) begin
                    m_owner = -1; m_beats = 0; m_rr = (g + 1) % N;
                end else begin
                    m_owner = g; m_beats = nb;
                end
            end else begin
                m_owner = -1; m_beats = 0; m_rr = (g + 1) % N;
            end
        end
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        logic [31:0] r;
        r = $urandom;
        return r[N*W-1:0];
    endfunction

    // Output monitor: every valid beat on O must match the oldest accepted beat
    always @(negedge CLK) begin
        exp_t e;
        if (O_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_O_valid: got O=%0d owner=%0d with no accepted beat", O, O_owner);
            end else begin
                e = sb.pop_front();
                chk("O_data", int'(O), int'(e.dat));
                chk("O_owner", int'(O_owner), int'(e.own));
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_inv
        a_inv: assert property (@(posedge CLK) disable iff (RESET)
            (req_valid[gi] && req_ready[gi]) |=> (O == $past(req_data[gi*W +: W]) && O_owner == OW'(gi)))
            else $error("FAIL invariant: requester %0d beat not reflected on O", gi);
    end

    initial begin
        RESET = 1'b1; req_valid = '0; req_last = '0; req_data = '0;

        // Reset with both requesters valid
        cycle(1'b1, 2'b11, 2'b00, rnd_data());
        cycle(1'b1, 2'b11, 2'b00, rnd_data());
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_O", int'(O), 0);
        chk("rst_O_valid", int'(O_valid), 0);
        chk("rst_busy", int'(busy), 0);

        // Continuous contention: bursts of 4 alternating, no bubbles
        cycle(1'b0, 2'b11, 2'b00, rnd_data());
        chk("post_rst_ready", int'(req_ready), 1);
        for (int c = 1; c < 16; c++) begin
            cycle(1'b0, 2'b11, 2'b00, rnd_data());
            chk("contend_ready", int'(req_ready), ((c / 4) % 2) ? 2 : 1);
            chk("contend_O_valid", int'(O_valid), 1);
            chk("contend_O_owner", int'(O_owner), ((c - 1) / 4) % 2);
        end

        // Early last on requester 0's second beat
        cycle(1'b1, 2'b00, 2'b00, '0);
        cycle(1'b0, 2'b11, 2'b00, rnd_data());
        cycle(1'b0, 2'b11, 2'b01, rnd_data());
        cycle(1'b0, 2'b11, 2'b00, rnd_data());
        chk("early_last_ready", int'(req_ready), 2);
        chk("early_last_busy", int'(busy), 0);

        // Owner drops valid on its third beat
        cycle(1'b1, 2'b00, 2'b00, '0);
        cycle(1'b0, 2'b11, 2'b00, rnd_data());
        cycle(1'b0, 2'b11, 2'b00, rnd_data());
        cycle(1'b0, 2'b10, 2'b00, rnd_data());
        cycle(1'b0, 2'b11, 2'b00, rnd_data());
        chk("drop_O_valid", int'(O_valid), 0);
        chk("drop_ready", int'(req_ready), 2);

        // Data integrity: requester 0 sends 1,0,1
        cycle(1'b1, 2'b00, 2'b00, '0);
        cycle(1'b0, 2'b01, 2'b00, {8'h00, 8'h01});
        cycle(1'b0, 2'b01, 2'b00, {8'h00, 8'h00});
        chk("data_b0", int'(O), 1);
        cycle(1'b0, 2'b01, 2'b00, {8'h00, 8'h01});
        chk("data_b1", int'(O), 0);
        cycle(1'b0, 2'b00, 2'b00, '0);
        chk("data_b2", int'(O), 1);
        chk("data_b2_valid", int'(O_valid), 1);

        // Reset mid-burst discards the beat and restarts the scan
        cycle(1'b0, 2'b00, 2'b00, '0);
        cycle(1'b0, 2'b11, 2'b00, rnd_data());
        cycle(1'b0, 2'b11, 2'b00, rnd_data());
        cycle(1'b1, 2'b11, 2'b00, rnd_data());
        cycle(1'b0, 2'b11, 2'b00, rnd_data());
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_O_valid", int'(O_valid), 0);
        chk("midrst_ready", int'(req_ready), 1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] v;
            logic [N-1:0] l;
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 3) != 0);
                l[i] = ($urandom_range(0, 3) == 0);
            end
            cycle(($urandom_range(0, 99) == 0), v, l, rnd_data());
        end

        cycle(1'b0, 2'b00, 2'b00, '0);
        cycle(1'b0, 2'b00, 2'b00, '0);
        cycle(1'b0, 2'b00, 2'b00, '0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
